// File: rtl/adc_sample_avg.sv
// adc_sample_avg
//   Consumes the LTC2315 capture stage output. A rising edge of the
//   chip-select marks the end of a conversion frame; after SETTLE cycles
//   the 12-bit sample is taken and folded into a 2^AVG_LOG2-deep moving
//   average. A hysteresis comparator on that average drives event_flag.
//
// Parameters
//   AVG_LOG2 : log2 of the averaging window depth (1..5)
//   SETTLE   : clk_100 cycles from CS rising edge to sampling (0..15)
//
// Ports
//   clk_100    : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   enable     : low clears the window and holds the block idle
//   adc_cs     : ADC chip-select (active low), rising edge = frame end
//   adc_data   : captured ADC word, bits [11:0] used
//   thr_hi     : event_flag sets when avg > thr_hi (set wins)
//   thr_lo     : event_flag clears when avg < thr_lo
//   avg        : current window average
//   avg_valid  : one-cycle pulse when avg updates from a full window
//   event_flag : hysteresis comparator state
//   event_rise : one-cycle pulse on 0->1 of event_flag
//   overrun    : one-cycle pulse when a CS edge arrives while busy
module adc_sample_avg #(
  parameter int unsigned AVG_LOG2 = 3,
  parameter int unsigned SETTLE   = 2
) (
  input  logic        clk_100,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_cs,
  input  logic [15:0] adc_data,
  input  logic [11:0] thr_hi,
  input  logic [11:0] thr_lo,
  output logic [11:0] avg,
  output logic        avg_valid,
  output logic        event_flag,
  output logic        event_rise,
  output logic        overrun
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = 12 + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_UPDATE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                r_cs_d;
  logic                w_edge;
  logic [3:0]          r_settle;
  logic [11:0]         r_buf [N];
  logic [SW-1:0]       r_sum;
  logic [AVG_LOG2-1:0] r_wr_ptr;
  logic [AVG_LOG2:0]   r_fill;
  logic [11:0]         r_sample;
  logic [11:0]         r_old;
  logic                r_upd_done;
  logic [11:0]         r_avg;
  logic                r_avg_valid;
  logic                r_flag;
  logic                r_rise;
  logic                r_overrun;

  // Upper nibble of the ADC word carries no sample information.
  logic w_adc_unused;
  assign w_adc_unused = ^adc_data[15:12];

  assign w_edge = adc_cs & ~r_cs_d;

  assign avg        = r_avg;
  assign avg_valid  = r_avg_valid;
  assign event_flag = r_flag;
  assign event_rise = r_rise;
  assign overrun    = r_overrun;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = (SETTLE == 0) ? S_CAPTURE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_settle == 4'd1) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: w_state_nxt = S_UPDATE;
      S_UPDATE:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      r_cs_d      <= 1'b1;
      r_settle    <= '0;
      r_sum       <= '0;
      r_wr_ptr    <= '0;
      r_fill      <= '0;
      r_sample    <= '0;
      r_old       <= '0;
      r_upd_done  <= 1'b0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_flag      <= 1'b0;
      r_rise      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_cs_d      <= adc_cs;
      r_overrun   <= enable && w_edge && (r_state != S_IDLE);
      r_upd_done  <= 1'b0;
      r_avg_valid <= 1'b0;
      r_rise      <= 1'b0;
      if (!enable) begin
        r_settle <= '0;
        r_sum    <= '0;
        r_wr_ptr <= '0;
        r_fill   <= '0;
        r_avg    <= '0;
        r_flag   <= 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
          r_buf[i] <= '0;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_edge) begin
              r_settle <= 4'(SETTLE);
            end
          end
          S_WAIT: r_settle <= r_settle - 4'd1;
          S_CAPTURE: begin
            r_sample <= adc_data[11:0];
            r_old    <= r_buf[r_wr_ptr];
          end
          S_UPDATE: begin
            // The evicted sample is always part of r_sum, so no underflow.
            r_sum           <= r_sum + SW'(r_sample) - SW'(r_old);
            r_buf[r_wr_ptr] <= r_sample;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
            if (r_fill != FULL) begin
              r_fill <= r_fill + 1'b1;
            end
            r_upd_done <= 1'b1;
          end
          default: ;
        endcase

        if (r_upd_done && (r_fill == FULL)) begin
          r_avg       <= r_sum[SW-1:AVG_LOG2];
          r_avg_valid <= 1'b1;
        end

        // Set is tested first so it wins when thr_lo > thr_hi.
        if (r_avg_valid) begin
          if (r_avg > thr_hi) begin
            r_flag <= 1'b1;
            r_rise <= ~r_flag;
          end else if (r_avg < thr_lo) begin
            r_flag <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_avg.sv
module tb_adc_sample_avg;

  localparam int unsigned AVG_LOG2 = 3;
  localparam int unsigned SETTLE   = 2;
  localparam int unsigned N        = 8;
  localparam int          LAT      = SETTLE + 3;

  logic        clk_100 = 1'b0;
  logic        reset;
  logic        enable;
  logic        adc_cs;
  logic [15:0] adc_data;
  logic [11:0] thr_hi;
  logic [11:0] thr_lo;
  logic [11:0] avg;
  logic        avg_valid;
  logic        event_flag;
  logic        event_rise;
  logic        overrun;

  adc_sample_avg #(
    .AVG_LOG2(AVG_LOG2),
    .SETTLE  (SETTLE)
  ) dut (
    .clk_100   (clk_100),
    .reset     (reset),
    .enable    (enable),
    .adc_cs    (adc_cs),
    .adc_data  (adc_data),
    .thr_hi    (thr_hi),
    .thr_lo    (thr_lo),
    .avg       (avg),
    .avg_valid (avg_valid),
    .event_flag(event_flag),
    .event_rise(event_rise),
    .overrun   (overrun)
  );

  always #5 clk_100 = ~clk_100;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: window of the last N accepted samples.
  int unsigned m_win[$];
  logic [11:0] m_avg;
  logic        m_valid;
  logic        m_flag;
  logic        m_rise;

  function automatic void model_clear();
    m_win.delete();
    m_avg   = '0;
    m_valid = 1'b0;
    m_flag  = 1'b0;
    m_rise  = 1'b0;
  endfunction

  function automatic void model_frame(input logic [15:0] d);
    int unsigned s;
    logic        prev;
    s = 0;
    m_win.push_back(int'(d) % 4096);
    if (m_win.size() > N) void'(m_win.pop_front());
    m_valid = (m_win.size() == N);
    m_rise  = 1'b0;
    if (m_valid) begin
      foreach (m_win[i]) s += m_win[i];
      m_avg = 12'(s / N);
      prev  = m_flag;
      if (m_avg > thr_hi) m_flag = 1'b1;
      else if (m_avg < thr_lo) m_flag = 1'b0;
      m_rise = m_flag & ~prev;
    end
  endfunction

  // Observations of one frame
  logic        ob_v_early, ob_v, ob_f, ob_r, ob_r2;
  logic [11:0] ob_a;
  int          ob_ovr;

  task automatic start_frame(input logic [15:0] d);
    @(negedge clk_100);
    adc_cs   = 1'b0;
    adc_data = d;
    @(negedge clk_100);
    adc_cs = 1'b1;
    @(posedge clk_100);  // edge E
  endtask

  // Called right after posedge E; sample j is taken half a cycle after E+j.
  task automatic observe(input bit dbl);
    ob_ovr = 0;
    for (int j = 0; j <= LAT + 2; j++) begin
      @(negedge clk_100);
      if (overrun) ob_ovr++;
      if (dbl && j == 0) adc_cs = 1'b0;
      if (dbl && j == 1) adc_cs = 1'b1;
      if (j == LAT - 1) ob_v_early = avg_valid;
      if (j == LAT) begin
        ob_v = avg_valid;
        ob_a = avg;
      end
      if (j == LAT + 1) begin
        ob_f = event_flag;
        ob_r = event_rise;
      end
      if (j == LAT + 2) ob_r2 = event_rise;
    end
  endtask

  task automatic frame(input logic [15:0] d, input bit dbl);
    start_frame(d);
    model_frame(d);
    observe(dbl);
  endtask

  task automatic check_model(input string name, input int exp_ovr);
    chk({name, ".valid_early"}, ob_v_early, 0);
    chk({name, ".valid"}, ob_v, m_valid);
    chk({name, ".avg"}, ob_a, m_avg);
    chk({name, ".flag"}, ob_f, m_flag);
    chk({name, ".rise"}, ob_r, m_rise);
    chk({name, ".rise_end"}, ob_r2, 0);
    chk({name, ".overrun"}, ob_ovr, exp_ovr);
  endtask

  task automatic check_zero(input string name);
    chk({name, ".avg"}, avg, 0);
    chk({name, ".avg_valid"}, avg_valid, 0);
    chk({name, ".event_flag"}, event_flag, 0);
    chk({name, ".event_rise"}, event_rise, 0);
    chk({name, ".overrun"}, overrun, 0);
  endtask

  typedef struct {
    logic [15:0] d;
    logic [11:0] hi;
    logic [11:0] lo;
    logic        v;
    logic [11:0] a;
    logic        f;
    logic        r;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [15:0] d, input logic [11:0] hi, input logic [11:0] lo,
                              input logic v, input logic [11:0] a, input logic f, input logic r);
    vec_t e;
    e.d = d; e.hi = hi; e.lo = lo; e.v = v; e.a = a; e.f = f; e.r = r;
    tbl.push_back(e);
  endfunction

  // Average after k of 8 window slots moved from value o to value n.
  function automatic logic [11:0] mix(input int o, input int n, input int k);
    return 12'((o * (8 - k) + n * k) / 8);
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Expected-output table
    for (int k = 1; k <= 8; k++) add(16'h0100, 12'hFFF, 12'h000, k == 8, (k == 8) ? 12'h100 : 12'h000, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) add(16'h0FFF, 12'hFFF, 12'h000, 1'b1, mix(12'h100, 12'hFFF, k), 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) add(16'hF123, 12'hFFF, 12'h000, 1'b1, mix(12'hFFF, 12'h123, k), 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) add(16'h0100, 12'h800, 12'h400, 1'b1, mix(12'h123, 12'h100, k), 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) add(16'h0900, 12'h800, 12'h400, 1'b1, mix(12'h100, 12'h900, k), k == 8, k == 8);
    for (int k = 1; k <= 8; k++) add(16'h0600, 12'h800, 12'h400, 1'b1, mix(12'h900, 12'h600, k), 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) add(16'h0300, 12'h800, 12'h400, 1'b1, mix(12'h600, 12'h300, k), k < 6, 1'b0);
    add(16'h0300, 12'h400, 12'h800, 1'b1, 12'h300, 1'b0, 1'b0);
    add(16'h0300, 12'h100, 12'h800, 1'b1, 12'h300, 1'b1, 1'b1);

    reset    = 1'b1;
    enable   = 1'b1;
    adc_cs   = 1'b1;
    adc_data = '0;
    thr_hi   = 12'hFFF;
    thr_lo   = 12'h000;
    model_clear();
    #12;
    check_zero("reset");
    #11;
    reset = 1'b0;

    foreach (tbl[i]) begin
      thr_hi = tbl[i].hi;
      thr_lo = tbl[i].lo;
      frame(tbl[i].d, 1'b0);
      chk($sformatf("tbl[%0d].valid_early", i), ob_v_early, 0);
      chk($sformatf("tbl[%0d].valid", i), ob_v, tbl[i].v);
      chk($sformatf("tbl[%0d].avg", i), ob_a, tbl[i].a);
      chk($sformatf("tbl[%0d].flag", i), ob_f, tbl[i].f);
      chk($sformatf("tbl[%0d].rise", i), ob_r, tbl[i].r);
      chk($sformatf("tbl[%0d].rise_end", i), ob_r2, 0);
    end

    // One-cycle disable; CS edge lands on the cycle enable returns.
    @(negedge clk_100);
    enable = 1'b0;
    adc_cs = 1'b0;
    @(negedge clk_100);
    check_zero("en_clear");
    model_clear();
    enable   = 1'b1;
    adc_cs   = 1'b1;
    adc_data = 16'h0350;
    @(posedge clk_100);
    model_frame(16'h0350);
    observe(1'b0);
    check_model("en_rise", 0);
    for (int i = 2; i <= 8; i++) begin
      logic [15:0] d;
      d = 16'(16'h0350 + i * 16'h0123);
      frame(d, i == 2);
      check_model($sformatf("refill[%0d]", i), (i == 2) ? 1 : 0);
    end

    // Async reset landing while the FSM is in UPDATE
    thr_hi = 12'h800;
    thr_lo = 12'h400;
    for (int i = 0; i < 8; i++) begin
      frame(16'h0A00, 1'b0);
      check_model($sformatf("prefill[%0d]", i), 0);
    end
    start_frame(16'h0777);
    repeat (3) @(posedge clk_100);
    #3 reset = 1'b1;
    #1 check_zero("rst_mid");
    #9 reset = 1'b0;
    model_clear();
    for (int i = 1; i <= 8; i++) begin
      frame(16'(16'h0200 + i * 16'h0051), 1'b0);
      check_model($sformatf("post_rst[%0d]", i), 0);
    end

    // Randomized frames against the reference model
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) begin
        thr_hi = 12'($urandom);
        thr_lo = 12'($urandom);
      end
      frame(16'($urandom), 1'b0);
      check_model($sformatf("rnd[%0d]", i), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk_100);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
